// File: rtl/char_writer.sv
// rtl/char_writer.sv - VT52-subset terminal writer feeding a 64x16 character buffer
// Tracks cursor and hardware scroll origin; clears run one cell per cycle with input stalled.
module char_writer #(
  parameter int         COLS_LOG2 = 6,
  parameter int         ROWS_LOG2 = 4,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                           pclk,
  input  logic                           clr,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] buf_addr,
  output logic [7:0]                     buf_din,
  output logic                           buf_wen,
  output logic [COLS_LOG2-1:0]           cursor_x,
  output logic [ROWS_LOG2-1:0]           cursor_y,
  output logic [ROWS_LOG2-1:0]           first_row
);

  localparam int AW = COLS_LOG2 + ROWS_LOG2;
  localparam logic [COLS_LOG2-1:0] X_MAX    = '1;
  localparam logic [ROWS_LOG2-1:0] Y_MAX    = '1;
  localparam logic [AW-1:0]        CELL_MAX = '1;
  localparam logic [COLS_LOG2-1:0] TAB_MASK = COLS_LOG2'(7);

  typedef enum logic [2:0] {S_IDLE, S_ESC, S_ESCY_ROW, S_ESCY_COL, S_CLEAR} state_t;

  state_t               r_state, w_state_n;
  logic [COLS_LOG2-1:0] r_cx, w_cx_n;
  logic [ROWS_LOG2-1:0] r_cy, w_cy_n;
  logic [ROWS_LOG2-1:0] r_first, w_first_n;
  logic                 r_wen, w_wen_n;
  logic [AW-1:0]        r_addr, w_addr_n;
  logic [7:0]           r_din, w_din_n;
  logic                 r_ready;
  logic [7:0]           r_row, w_row_n;
  logic [AW-1:0]        r_cnt, w_cnt_n;
  logic [AW-1:0]        r_last, w_last_n;

  logic                 w_take;
  logic [ROWS_LOG2-1:0] w_phys_row;
  logic [ROWS_LOG2-1:0] w_clr_row;
  logic [COLS_LOG2-1:0] w_tab;
  logic [7:0]           w_col;

  assign w_take     = in_valid && (r_state != S_CLEAR);
  assign w_phys_row = r_cy + r_first;
  assign w_clr_row  = r_cnt[AW-1:COLS_LOG2] + r_first;
  assign w_tab      = r_cx | TAB_MASK;
  assign w_col      = in_data - 8'h20;

  always_ff @(posedge pclk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_first <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_ready <= 1'b1;
      r_row   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cx    <= w_cx_n;
      r_cy    <= w_cy_n;
      r_first <= w_first_n;
      r_wen   <= w_wen_n;
      r_addr  <= w_addr_n;
      r_din   <= w_din_n;
      r_ready <= (w_state_n != S_CLEAR);
      r_row   <= w_row_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cx_n    = r_cx;
    w_cy_n    = r_cy;
    w_first_n = r_first;
    w_wen_n   = 1'b0;
    w_addr_n  = r_addr;
    w_din_n   = r_din;
    w_row_n   = r_row;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            w_wen_n  = 1'b1;
            w_addr_n = {w_phys_row, r_cx};
            w_din_n  = in_data;
            if (r_cx != X_MAX) w_cx_n = r_cx + 1'b1;
          end else begin
            case (in_data)
              8'h0D: w_cx_n = '0;
              8'h08: if (r_cx != '0) w_cx_n = r_cx - 1'b1;
              8'h09: w_cx_n = (w_tab == X_MAX) ? X_MAX : w_tab + 1'b1;
              8'h0A: begin
                if (r_cy != Y_MAX) begin
                  w_cy_n = r_cy + 1'b1;
                end else begin
                  // Scroll: the old top row becomes the new bottom row and is blanked.
                  w_first_n = r_first + 1'b1;
                  w_cnt_n   = {Y_MAX, {COLS_LOG2{1'b0}}};
                  w_last_n  = CELL_MAX;
                  w_state_n = S_CLEAR;
                end
              end
              8'h1B:   w_state_n = S_ESC;
              default: ;
            endcase
          end
        end
      end
      S_ESC: begin
        if (w_take) begin
          w_state_n = S_IDLE;
          case (in_data)
            8'h41: if (r_cy != '0) w_cy_n = r_cy - 1'b1;
            8'h42: if (r_cy != Y_MAX) w_cy_n = r_cy + 1'b1;
            8'h43: if (r_cx != X_MAX) w_cx_n = r_cx + 1'b1;
            8'h44: if (r_cx != '0) w_cx_n = r_cx - 1'b1;
            8'h48: begin
              w_cx_n = '0;
              w_cy_n = '0;
            end
            8'h49: begin
              if (r_cy != '0) begin
                w_cy_n = r_cy - 1'b1;
              end else begin
                w_first_n = r_first - 1'b1;
                w_cnt_n   = '0;
                w_last_n  = {{ROWS_LOG2{1'b0}}, X_MAX};
                w_state_n = S_CLEAR;
              end
            end
            8'h4B: begin
              w_cnt_n   = {r_cy, r_cx};
              w_last_n  = {r_cy, X_MAX};
              w_state_n = S_CLEAR;
            end
            8'h4A: begin
              w_cnt_n   = {r_cy, r_cx};
              w_last_n  = CELL_MAX;
              w_state_n = S_CLEAR;
            end
            8'h59:   w_state_n = S_ESCY_ROW;
            default: ;
          endcase
        end
      end
      S_ESCY_ROW: begin
        if (w_take) begin
          w_row_n   = in_data - 8'h20;
          w_state_n = S_ESCY_COL;
        end
      end
      S_ESCY_COL: begin
        if (w_take) begin
          // Bytes below 0x20 wrap to large values and are rejected by the range checks.
          if (r_row <= 8'(Y_MAX)) w_cy_n = r_row[ROWS_LOG2-1:0];
          if (w_col <= 8'(X_MAX)) w_cx_n = w_col[COLS_LOG2-1:0];
          w_state_n = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_wen_n  = 1'b1;
        w_addr_n = {w_clr_row, r_cnt[COLS_LOG2-1:0]};
        w_din_n  = FILL_CHAR;
        if (r_cnt == r_last) w_state_n = S_IDLE;
        else                 w_cnt_n   = r_cnt + 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign in_ready  = r_ready;
  assign buf_addr  = r_addr;
  assign buf_din   = r_din;
  assign buf_wen   = r_wen;
  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign first_row = r_first;

endmodule
